hilo_mult_ctrl: RTL and testbench

Sequencer for the 6-stage pipelined unsigned 32x32 multiplier in the MIPS execute stage. It accepts MULT/MULTU/MFHI/MFLO/MTHI/MTLO operations from the decoder and drives the multiplier operands. For MULT it performs signed correction around the unsigned core, writes the 64-bit product into the HI/LO registers, and stalls HI/LO accesses while a multiply is in flight.

---
 rtl/hilo_mult_ctrl_if.sv | 28 ++
 rtl/hilo_mult_ctrl.sv | 133 +++++++++++++
 tb/tb_hilo_mult_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_mult_ctrl_if.sv
// hilo_mult_ctrl_if
//   Operation request / read-result bundle between the decoder (master) and
//   the HI/LO multiply sequencer (slave).
//   op_valid/op_ready : request handshake, transfer when both are high
//   op_code           : 000 MULT, 001 MULTU, 010 MFHI, 011 MFLO,
//                       100 MTHI, 101 MTLO, 110/111 reserved
//   rs_val/rt_val     : operands (rs_val is also the MTHI/MTLO source)
//   res_valid         : one-cycle pulse, res_data holds the MFHI/MFLO result
//   res_data          : read data
interface hilo_mult_ctrl_if;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_code;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        res_valid;
    logic [31:0] res_data;

    modport master (
        output op_valid, op_code, rs_val, rt_val,
        input  op_ready, res_valid, res_data
    );

    modport slave (
        input  op_valid, op_code, rs_val, rt_val,
        output op_ready, res_valid, res_data
    );
endinterface

// File: rtl/hilo_mult_ctrl.sv
// hilo_mult_ctrl
//   Sequencer for the pipelined unsigned 32x32 multiplier feeding HI/LO.
//   MULT runs the unsigned core on operand magnitudes and negates the product
//   when the operand signs differ. HI/LO accesses stall while a multiply is
//   in flight.
//   clk, rst     : clock, asynchronous active-low reset
//   bus          : request handshake and read-result (slave side)
//   mul_a, mul_b : registered multiplier operands
//   mul_z        : multiplier product, MUL_LAT cycles after operand sample
//   hi, lo       : HI/LO registers
//   busy         : multiply in flight
//
//   state | meaning
//   IDLE  | accepting operations
//   MUL   | waiting for the product, requests held off
module hilo_mult_ctrl #(
    parameter int MUL_LAT = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    hilo_mult_ctrl_if.slave        bus,
    output logic [31:0]            mul_a,
    output logic [31:0]            mul_b,
    input  logic [63:0]            mul_z,
    output logic [31:0]            hi,
    output logic [31:0]            lo,
    output logic                   busy
);

    localparam int CW = $clog2(MUL_LAT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MFHI  = 3'd2;
    localparam logic [2:0] OP_MFLO  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {IDLE, MUL} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          neg;
    logic          accept;
    logic          mul_done;
    logic [63:0]   prod;

    // |0x80000000| wraps back to 0x80000000, which is the correct unsigned
    // magnitude for the core.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    assign prod = neg ? (~mul_z + 64'd1) : mul_z;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        mul_done     = 1'b0;
        bus.op_ready = 1'b0;
        busy         = 1'b0;
        case (state)
            IDLE: begin
                bus.op_ready = 1'b1;
                accept       = bus.op_valid;
                if (bus.op_valid && (bus.op_code == OP_MULT || bus.op_code == OP_MULTU))
                    state_nxt = MUL;
            end
            MUL: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) begin
                    mul_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            mul_a        <= '0;
            mul_b        <= '0;
            neg          <= 1'b0;
            hi           <= '0;
            lo           <= '0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
        end else begin
            bus.res_valid <= 1'b0;
            if (state == MUL)
                cnt <= mul_done ? '0 : cnt + CW'(1);
            if (mul_done)
                {hi, lo} <= prod;
            if (accept) begin
                case (bus.op_code)
                    OP_MULT: begin
                        mul_a <= abs32(bus.rs_val);
                        mul_b <= abs32(bus.rt_val);
                        neg   <= bus.rs_val[31] ^ bus.rt_val[31];
                        cnt   <= '0;
                    end
                    OP_MULTU: begin
                        mul_a <= bus.rs_val;
                        mul_b <= bus.rt_val;
                        neg   <= 1'b0;
                        cnt   <= '0;
                    end
                    OP_MFHI: begin
                        bus.res_data  <= hi;
                        bus.res_valid <= 1'b1;
                    end
                    OP_MFLO: begin
                        bus.res_data  <= lo;
                        bus.res_valid <= 1'b1;
                    end
                    OP_MTHI: hi <= bus.rs_val;
                    OP_MTLO: lo <= bus.rs_val;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// tb_hilo_mult_ctrl
//   Drives directed and random MULT/MULTU/MF/MT traffic into hilo_mult_ctrl,
//   with a 6-stage unsigned multiplier model attached to mul_a/mul_b/mul_z.
//   A transaction-level model (signed/unsigned 64-bit products committed
//   seven edges after acceptance) is compared against the DUT every cycle.
module tb_hilo_mult_ctrl;

    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, MFHI = 3'd2, MFLO = 3'd3,
                           MTHI = 3'd4, MTLO = 3'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] mul_a, mul_b, hi, lo;
    logic [63:0] mul_z;
    logic        busy;
    logic [63:0] pipe [6];

    int n_chk  = 0;
    int n_fail = 0;

    hilo_mult_ctrl_if bus ();

    hilo_mult_ctrl #(.MUL_LAT(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .mul_a (mul_a),
        .mul_b (mul_b),
        .mul_z (mul_z),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Unsigned multiplier core: samples operands every edge, six register stages.
    always @(posedge clk) begin
        pipe[0] <= {32'd0, mul_a} * {32'd0, mul_b};
        for (int i = 1; i < 6; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_z = pipe[5];

    // ---------------- reference model ----------------
    logic [31:0] m_hi, m_lo, m_a, m_b, m_rd;
    logic        m_rv, m_pend, acc;
    logic [63:0] m_prod;
    int          cyc, m_due;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_hi = 0; m_lo = 0; m_a = 0; m_b = 0; m_rd = 0;
            m_rv = 0; m_pend = 0; m_prod = 0; cyc = 0; m_due = 0;
        end else begin
            acc = bus.op_valid && !m_pend;
            cyc++;
            m_rv = 0;
            if (m_pend && cyc == m_due) begin
                {m_hi, m_lo} = m_prod;
                m_pend = 0;
            end
            if (acc) begin
                case (bus.op_code)
                    MULT: begin
                        m_prod = 64'(longint'($signed(bus.rs_val)) * longint'($signed(bus.rt_val)));
                        m_a = bus.rs_val[31] ? -bus.rs_val : bus.rs_val;
                        m_b = bus.rt_val[31] ? -bus.rt_val : bus.rt_val;
                        m_pend = 1; m_due = cyc + 7;
                    end
                    MULTU: begin
                        m_prod = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};
                        m_a = bus.rs_val; m_b = bus.rt_val;
                        m_pend = 1; m_due = cyc + 7;
                    end
                    MFHI: begin m_rd = m_hi; m_rv = 1; end
                    MFLO: begin m_rd = m_lo; m_rv = 1; end
                    MTHI: m_hi = bus.rs_val;
                    MTLO: m_lo = bus.rs_val;
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("op_ready",  64'(bus.op_ready),  64'(!m_pend));
            check("busy",      64'(busy),          64'(m_pend));
            check("hi",        64'(hi),            64'(m_hi));
            check("lo",        64'(lo),            64'(m_lo));
            check("res_valid", 64'(bus.res_valid), 64'(m_rv));
            check("res_data",  64'(bus.res_data),  64'(m_rd));
            check("mul_a",     64'(mul_a),         64'(m_a));
            check("mul_b",     64'(mul_b),         64'(m_b));
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge; returns at the negedge after the accepting edge,
    // leaving op_valid high so a following issue is back-to-back.
    task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        bus.op_valid = 1'b1;
        bus.op_code  = c;
        bus.rs_val   = a;
        bus.rt_val   = b;
        while (!bus.op_ready) begin
            @(negedge clk);
            n++;
            if (n > 50) begin
                check("issue_timeout", 64'(n), 64'd0);
                break;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.op_valid = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.op_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic mul_case(input string nm, input logic [2:0] c, input logic [31:0] a,
                            input logic [31:0] b, input logic [63:0] exp);
        int n;
        issue(c, a, b);
        idle(0);
        wait_ready(n);
        check({nm, "_hilo"},  {hi, lo},     exp);
        check({nm, "_model"}, {m_hi, m_lo}, exp);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int n;
        bus.op_valid = 0; bus.op_code = 0; bus.rs_val = 0; bus.rt_val = 0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_hi",    64'(hi), 64'd0);
        check("rst_lo",    64'(lo), 64'd0);
        check("rst_ready", 64'(bus.op_ready), 64'd1);
        check("rst_rv",    64'(bus.res_valid), 64'd0);
        check("rst_mula",  64'(mul_a), 64'd0);

        // MULTU max x max, latency, then reads
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(0);
        check("busy_e0", 64'(bus.op_ready), 64'd0);
        wait_ready(n);
        check("mul_latency", 64'(n), 64'd7);
        check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        check("multu_lo", 64'(lo), 64'h0000_0001);
        issue(MFHI, 0, 0);
        check("mfhi_rv",   64'(bus.res_valid), 64'd1);
        check("mfhi_data", 64'(bus.res_data), 64'hFFFF_FFFE);
        issue(MFLO, 0, 0);
        check("mflo_rv",   64'(bus.res_valid), 64'd1);
        check("mflo_data", 64'(bus.res_data), 64'h0000_0001);
        idle(1);
        check("rv_drop", 64'(bus.res_valid), 64'd0);

        mul_case("m1",  MULT, 32'hFFFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF);
        mul_case("m2",  MULT, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000);
        mul_case("m3",  MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        mul_case("m4",  MULT, 32'h0000_0000, 32'h8000_0000, 64'h0000_0000_0000_0000);

        // MFLO held through a MULT: -2 * 3 = -6
        issue(MULT, 32'hFFFF_FFFE, 32'h0000_0003);
        issue(MFLO, 0, 0);
        check("held_mflo", 64'(bus.res_data), 64'hFFFF_FFFA);
        check("held_rv",   64'(bus.res_valid), 64'd1);

        issue(MTHI, 32'h1234_5678, 0);
        issue(MFHI, 0, 0);
        check("mthi_mfhi", 64'(bus.res_data), 64'h1234_5678);

        // reset in the middle of a multiply
        issue(MTHI, 32'hAAAA_5555, 0);
        issue(MTLO, 32'hAAAA_5555, 0);
        issue(MULTU, 32'd5, 32'd7);
        idle(2);
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("mid_rst_hi",    64'(hi), 64'd0);
        check("mid_rst_lo",    64'(lo), 64'd0);
        check("mid_rst_ready", 64'(bus.op_ready), 64'd1);
        idle(10);
        check("no_late_wr", {hi, lo}, 64'd0);
        mul_case("m5", MULTU, 32'd5, 32'd7, 64'd35);

        // reserved opcode: no read pulse, nothing changes
        issue(3'd6, 32'hDEAD_BEEF, 0);
        idle(0);
        check("rsvd_rv", 64'(bus.res_valid), 64'd0);
        check("rsvd_hl", {hi, lo}, 64'd35);

        // random sweep, checked by the per-cycle compare
        for (int i = 0; i < 1200; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick());
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
